// File: rtl/weight_load_ctrl.sv
// Filter-load sequencer for the conv weight_buffer: streams one R x S filter per pass,
// hands it to the conv engine, and repeats for every filter in the layer.
module weight_load_ctrl #(
    parameter int INPUT_WIDTH  = 32,
    parameter int WEIGHT_WIDTH = 8,
    parameter int MAX_RS       = 5,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CFG_START,
    input  logic [3:0]             CFG_R,
    input  logic [3:0]             CFG_S,
    input  logic [CNT_WIDTH-1:0]   CFG_NUM_FILTERS,
    input  logic [INPUT_WIDTH-1:0] S_TDATA,
    input  logic                   S_TVALID,
    output logic                   S_TREADY,
    output logic                   WB_WR_EN,
    output logic                   WB_WR_VALID,
    output logic [INPUT_WIDTH-1:0] WB_WR_DATA,
    output logic [3:0]             WB_PARAM_R,
    output logic [3:0]             WB_PARAM_S,
    output logic                   WB_CLEAR,
    input  logic                   WB_FULL,
    output logic                   ENG_WEIGHTS_READY,
    input  logic                   ENG_DONE,
    output logic [CNT_WIDTH-1:0]   FILTER_IDX,
    output logic                   BUSY,
    output logic                   LAYER_DONE,
    output logic                   CFG_ERR
);

    localparam int MAX_WORDS = (MAX_RS * MAX_RS * WEIGHT_WIDTH + INPUT_WIDTH - 1) / INPUT_WIDTH;
    localparam int WCNT_W    = $clog2(MAX_WORDS + 1);

    localparam logic [3:0]           MAX_RS_4 = 4'(MAX_RS);
    localparam logic [WCNT_W-1:0]    WCNT_ONE = WCNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_WAIT_FULL,
        S_READY
    } state_t;

    state_t                 state_q,       state_d;
    logic [3:0]             param_r_q,     param_r_d;
    logic [3:0]             param_s_q,     param_s_d;
    logic [CNT_WIDTH-1:0]   num_filters_q, num_filters_d;
    logic [WCNT_W-1:0]      wpf_q,         wpf_d;
    logic [WCNT_W-1:0]      word_cnt_q,    word_cnt_d;
    logic [CNT_WIDTH-1:0]   filter_idx_q,  filter_idx_d;
    logic                   clear_q,       clear_d;
    logic                   ready_q,       ready_d;
    logic                   busy_q,        busy_d;
    logic                   layer_done_q,  layer_done_d;
    logic                   cfg_err_q,     cfg_err_d;

    logic                   in_load;
    logic                   s_tready;
    logic                   accept;
    logic                   cfg_bad;
    logic [31:0]            cfg_bits;
    logic [WCNT_W-1:0]      cfg_wpf;

    // Words per filter: R*S weights packed into stream words, rounded up.
    assign cfg_bits = 32'(CFG_R) * 32'(CFG_S) * 32'(WEIGHT_WIDTH);
    assign cfg_wpf  = WCNT_W'((cfg_bits + 32'(INPUT_WIDTH - 1)) / 32'(INPUT_WIDTH));
    assign cfg_bad  = (CFG_R == '0) || (CFG_S == '0) || (CFG_R > MAX_RS_4) || (CFG_S > MAX_RS_4);

    // An early FULL from the buffer throttles the stream immediately.
    assign in_load  = (state_q == S_LOAD);
    assign s_tready = in_load && !WB_FULL;
    assign accept   = S_TVALID && s_tready;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d       = state_q;
        param_r_d     = param_r_q;
        param_s_d     = param_s_q;
        num_filters_d = num_filters_q;
        wpf_d         = wpf_q;
        word_cnt_d    = word_cnt_q;
        filter_idx_d  = filter_idx_q;
        cfg_err_d     = cfg_err_q;
        layer_done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (CFG_START) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        cfg_err_d     = 1'b0;
                        param_r_d     = CFG_R;
                        param_s_d     = CFG_S;
                        num_filters_d = CFG_NUM_FILTERS;
                        wpf_d         = cfg_wpf;
                        filter_idx_d  = '0;
                        if (CFG_NUM_FILTERS == '0) begin
                            layer_done_d = 1'b1;
                        end else begin
                            state_d = S_CLEAR;
                        end
                    end
                end
            end
            S_CLEAR: begin
                word_cnt_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                if (WB_FULL) begin
                    state_d = S_READY;
                end else if (accept) begin
                    word_cnt_d = word_cnt_q + WCNT_ONE;
                    if (word_cnt_q + WCNT_ONE == wpf_q) begin
                        state_d = S_WAIT_FULL;
                    end
                end
            end
            S_WAIT_FULL: begin
                if (WB_FULL) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (ENG_DONE) begin
                    if (filter_idx_q + CNT_ONE == num_filters_q) begin
                        filter_idx_d = '0;
                        layer_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        filter_idx_d = filter_idx_q + CNT_ONE;
                        state_d      = S_CLEAR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        clear_d = (state_d == S_CLEAR);
        ready_d = (state_d == S_READY);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            param_r_q     <= '0;
            param_s_q     <= '0;
            num_filters_q <= '0;
            wpf_q         <= '0;
            word_cnt_q    <= '0;
            filter_idx_q  <= '0;
            clear_q       <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the same pre-edge _d values.
            state_q       <= state_d;
            param_r_q     <= param_r_d;
            param_s_q     <= param_s_d;
            num_filters_q <= num_filters_d;
            wpf_q         <= wpf_d;
            word_cnt_q    <= word_cnt_d;
            filter_idx_q  <= filter_idx_d;
            clear_q       <= clear_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
            layer_done_q  <= layer_done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign S_TREADY          = s_tready;
    assign WB_WR_EN          = in_load;
    assign WB_WR_VALID       = accept;
    assign WB_WR_DATA        = in_load ? S_TDATA : '0;
    assign WB_PARAM_R        = param_r_q;
    assign WB_PARAM_S        = param_s_q;
    assign WB_CLEAR          = clear_q;
    assign ENG_WEIGHTS_READY = ready_q;
    assign FILTER_IDX        = filter_idx_q;
    assign BUSY              = busy_q;
    assign LAYER_DONE        = layer_done_q;
    assign CFG_ERR           = cfg_err_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: random weight stream with a word scoreboard and a
// small weight_buffer FULL model, driving the layer scenarios one after another.
module tb_weight_load_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CFG_START;
    logic [3:0]  CFG_R;
    logic [3:0]  CFG_S;
    logic [15:0] CFG_NUM_FILTERS;
    logic [31:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TREADY;
    logic        WB_WR_EN;
    logic        WB_WR_VALID;
    logic [31:0] WB_WR_DATA;
    logic [3:0]  WB_PARAM_R;
    logic [3:0]  WB_PARAM_S;
    logic        WB_CLEAR;
    logic        WB_FULL;
    logic        ENG_WEIGHTS_READY;
    logic        ENG_DONE;
    logic [15:0] FILTER_IDX;
    logic        BUSY;
    logic        LAYER_DONE;
    logic        CFG_ERR;

    always #5 CLK = ~CLK;

    weight_load_ctrl #(
        .INPUT_WIDTH (32),
        .WEIGHT_WIDTH(8),
        .MAX_RS      (5),
        .CNT_WIDTH   (16)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .CFG_START        (CFG_START),
        .CFG_R            (CFG_R),
        .CFG_S            (CFG_S),
        .CFG_NUM_FILTERS  (CFG_NUM_FILTERS),
        .S_TDATA          (S_TDATA),
        .S_TVALID         (S_TVALID),
        .S_TREADY         (S_TREADY),
        .WB_WR_EN         (WB_WR_EN),
        .WB_WR_VALID      (WB_WR_VALID),
        .WB_WR_DATA       (WB_WR_DATA),
        .WB_PARAM_R       (WB_PARAM_R),
        .WB_PARAM_S       (WB_PARAM_S),
        .WB_CLEAR         (WB_CLEAR),
        .WB_FULL          (WB_FULL),
        .ENG_WEIGHTS_READY(ENG_WEIGHTS_READY),
        .ENG_DONE         (ENG_DONE),
        .FILTER_IDX       (FILTER_IDX),
        .BUSY             (BUSY),
        .LAYER_DONE       (LAYER_DONE),
        .CFG_ERR          (CFG_ERR)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each stream word is queued when generated, popped when the DUT writes it.
    logic [31:0] exp_q[$];
    logic [31:0] cur_word;
    logic [31:0] sb_exp;

    bit src_taken, wr_seen, clr_seen, rst_seen;
    bit busy_seen, tready_seen, prev_full, prev_rdy;
    int valid_pct, buf_cap, buf_cnt;
    int cyc, acc_cnt, first_acc, last_acc, clr_cnt, ld_cnt, full_cyc, rdy_cyc;

    function automatic int wpf(input int r, input int s);
        return (r * s * 8 + 31) / 32;
    endfunction

    function automatic logic [63:0] outs();
        return {S_TREADY, WB_WR_EN, WB_WR_VALID, WB_WR_DATA, WB_PARAM_R, WB_PARAM_S,
                WB_CLEAR, ENG_WEIGHTS_READY, FILTER_IDX, BUSY, LAYER_DONE, CFG_ERR};
    endfunction

    // Monitor on the falling edge: inputs and outputs are settled for the next rising edge.
    always @(negedge CLK) begin
        cyc++;
        rst_seen  = RESET;
        clr_seen  = WB_CLEAR;
        wr_seen   = WB_WR_EN && WB_WR_VALID && !RESET;
        src_taken = S_TVALID && S_TREADY && !RESET;
        if (BUSY)       busy_seen   = 1'b1;
        if (S_TREADY)   tready_seen = 1'b1;
        if (WB_CLEAR)   clr_cnt++;
        if (LAYER_DONE) ld_cnt++;
        if (WB_FULL && !prev_full)          full_cyc = cyc;
        if (ENG_WEIGHTS_READY && !prev_rdy) rdy_cyc  = cyc;
        prev_full = WB_FULL;
        prev_rdy  = ENG_WEIGHTS_READY;
        if (src_taken) begin
            check("wr_en", 64'(WB_WR_EN), 64'd1);
            check("wr_valid", 64'(WB_WR_VALID), 64'd1);
            check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                sb_exp = exp_q.pop_front();
                check("wr_data", 64'(WB_WR_DATA), 64'(sb_exp));
            end
            if (acc_cnt == 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
        end
    end

    // Stream source and weight_buffer fill model, updated just after each rising edge.
    always @(posedge CLK) begin
        #1;
        if (rst_seen || clr_seen) buf_cnt = 0;
        else if (wr_seen)         buf_cnt++;
        WB_FULL = (buf_cnt >= buf_cap);
        if (src_taken) begin
            cur_word = $urandom;
            exp_q.push_back(cur_word);
        end
        S_TDATA  = cur_word;
        S_TVALID = (int'($urandom_range(99)) < valid_pct);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [3:0] r, input logic [3:0] s, input logic [15:0] n);
        CFG_R = r;
        CFG_S = s;
        CFG_NUM_FILTERS = n;
        CFG_START = 1'b1;
        tick(1);
        CFG_START = 1'b0;
    endtask

    task automatic done_pulse();
        ENG_DONE = 1'b1;
        tick(1);
        ENG_DONE = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ENG_WEIGHTS_READY && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, "_ready"}, 64'(ENG_WEIGHTS_READY), 64'd1);
        tick(1);
        check({tag, "_ready_hold"}, 64'(ENG_WEIGHTS_READY), 64'd1);
    endtask

    task automatic wait_words(input string tag, input int target);
        int n = 0;
        while (acc_cnt < target && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, "_words_reached"}, 64'(acc_cnt), 64'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        CFG_START = 1'b0;
        CFG_R = '0;
        CFG_S = '0;
        CFG_NUM_FILTERS = '0;
        ENG_DONE = 1'b0;
        WB_FULL = 1'b0;
        valid_pct = 100;
        buf_cap = wpf(5, 5);
        cur_word = $urandom;
        exp_q.push_back(cur_word);
        S_TDATA = cur_word;
        S_TVALID = 1'b0;

        tick(2);
        check("reset_outs", outs(), 64'd0);
        RESET = 1'b0;
        tick(1);

        // 1: 5x5, one filter, stream always valid
        valid_pct = 100; buf_cap = wpf(5, 5); acc_cnt = 0; clr_cnt = 0;
        start(4'd5, 4'd5, 16'd1);
        check("t1_busy", 64'(BUSY), 64'd1);
        check("t1_clear", 64'(WB_CLEAR), 64'd1);
        wait_ready("t1");
        check("t1_words", 64'(acc_cnt), 64'd7);
        check("t1_consecutive", 64'(last_acc - first_acc), 64'd6);
        check("t1_clears", 64'(clr_cnt), 64'd1);
        check("t1_ready_after_full", 64'(rdy_cyc - full_cyc), 64'd1);
        check("t1_params", 64'({WB_PARAM_R, WB_PARAM_S}), 64'h55);
        check("t1_tready_off", 64'(S_TREADY), 64'd0);
        done_pulse();
        check("t1_layer_done", 64'(LAYER_DONE), 64'd1);
        check("t1_idle", 64'(BUSY), 64'd0);
        tick(1);
        check("t1_layer_done_pulse", 64'(LAYER_DONE), 64'd0);

        // 2: 4x4, three filters, 50% valid
        valid_pct = 50; buf_cap = wpf(4, 4); clr_cnt = 0; ld_cnt = 0;
        start(4'd4, 4'd4, 16'd3);
        for (int k = 0; k < 3; k++) begin
            acc_cnt = 0;
            wait_ready("t2");
            check("t2_words", 64'(acc_cnt), 64'd4);
            check("t2_idx", 64'(FILTER_IDX), 64'(k));
            tick(9);
            done_pulse();
            if (k < 2) check("t2_busy_next", 64'(BUSY), 64'd1);
        end
        check("t2_layer_done", 64'(LAYER_DONE), 64'd1);
        check("t2_idx_cleared", 64'(FILTER_IDX), 64'd0);
        tick(1);
        check("t2_clears", 64'(clr_cnt), 64'd3);
        check("t2_ld_count", 64'(ld_cnt), 64'd1);

        // 3: bad configs, then a good one
        start(4'd6, 4'd3, 16'd1);
        check("t3_err_r6", 64'(CFG_ERR), 64'd1);
        check("t3_busy_r6", 64'(BUSY), 64'd0);
        check("t3_params_kept", 64'({WB_PARAM_R, WB_PARAM_S}), 64'h44);
        start(4'd3, 4'd0, 16'd1);
        check("t3_err_s0", 64'(CFG_ERR), 64'd1);
        tick(3);
        check("t3_busy_stays", 64'(BUSY), 64'd0);
        buf_cap = wpf(3, 3); acc_cnt = 0; valid_pct = 100;
        start(4'd3, 4'd3, 16'd1);
        check("t3_err_cleared", 64'(CFG_ERR), 64'd0);
        check("t3_busy", 64'(BUSY), 64'd1);
        wait_ready("t3");
        check("t3_words", 64'(acc_cnt), 64'd3);
        done_pulse();
        check("t3_layer_done", 64'(LAYER_DONE), 64'd1);
        tick(1);

        // 4: zero filters
        start(4'd0, 4'd1, 16'd1);
        check("t4_err_pre", 64'(CFG_ERR), 64'd1);
        busy_seen = 1'b0; tready_seen = 1'b0; ld_cnt = 0;
        start(4'd2, 4'd2, 16'd0);
        check("t4_layer_done", 64'(LAYER_DONE), 64'd1);
        check("t4_err", 64'(CFG_ERR), 64'd0);
        check("t4_params", 64'({WB_PARAM_R, WB_PARAM_S}), 64'h22);
        tick(5);
        check("t4_busy_never", 64'(busy_seen), 64'd0);
        check("t4_tready_never", 64'(tready_seen), 64'd0);
        check("t4_ld_count", 64'(ld_cnt), 64'd1);

        // 5: reset after the third word of a 5x5 load, then restart
        valid_pct = 100; buf_cap = wpf(5, 5); acc_cnt = 0;
        start(4'd5, 4'd5, 16'd1);
        wait_words("t5", 3);
        RESET = 1'b1;
        tick(1);
        check("t5_reset_outs", outs(), 64'd0);
        check("t5_words_before", 64'(acc_cnt), 64'd3);
        RESET = 1'b0;
        tick(1);
        acc_cnt = 0;
        start(4'd5, 4'd5, 16'd1);
        wait_ready("t5");
        check("t5_words_restart", 64'(acc_cnt), 64'd7);
        done_pulse();
        check("t5_layer_done", 64'(LAYER_DONE), 64'd1);
        tick(1);

        // 6: ENG_DONE and CFG_START during LOAD are ignored
        valid_pct = 50; buf_cap = wpf(5, 5); acc_cnt = 0;
        start(4'd5, 4'd5, 16'd2);
        wait_words("t6", 2);
        CFG_R = 4'd1; CFG_S = 4'd1; CFG_NUM_FILTERS = 16'd9;
        CFG_START = 1'b1; ENG_DONE = 1'b1;
        tick(1);
        CFG_START = 1'b0; ENG_DONE = 1'b0;
        check("t6_idx", 64'(FILTER_IDX), 64'd0);
        check("t6_params", 64'({WB_PARAM_R, WB_PARAM_S}), 64'h55);
        check("t6_busy", 64'(BUSY), 64'd1);
        check("t6_not_ready", 64'(ENG_WEIGHTS_READY), 64'd0);
        wait_ready("t6a");
        check("t6_words_f0", 64'(acc_cnt), 64'd7);
        check("t6_idx_f0", 64'(FILTER_IDX), 64'd0);
        done_pulse();
        acc_cnt = 0;
        wait_ready("t6b");
        check("t6_words_f1", 64'(acc_cnt), 64'd7);
        check("t6_idx_f1", 64'(FILTER_IDX), 64'd1);
        done_pulse();
        check("t6_layer_done", 64'(LAYER_DONE), 64'd1);
        tick(1);

        // 7: buffer reports FULL early, after two words
        valid_pct = 100; buf_cap = 2; acc_cnt = 0;
        start(4'd5, 4'd5, 16'd1);
        wait_ready("t7");
        check("t7_words", 64'(acc_cnt), 64'd2);
        check("t7_tready_off", 64'(S_TREADY), 64'd0);
        done_pulse();
        check("t7_layer_done", 64'(LAYER_DONE), 64'd1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
